// File: rtl/apb_pkg.sv
// Shared APB definitions for the requester-to-completer fan-out stage.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } splitter_state_t;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/apb_addr_decoder.sv
// Base/mask window decoder; returns a one-hot hit vector with the lowest
// matching index taking priority when windows overlap.
module apb_addr_decoder #(
    parameter int unsigned                          NUM_SLAVES = 4,
    parameter int unsigned                          ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]     SLV_BASE   = {32'h4000_3000, 32'h4000_2000,
                                                                  32'h4000_1000, 32'h4000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]     SLV_MASK   = {4{32'hFFFF_F000}}
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  hit_any
);

    // Walk from the top index down so the lowest matching window is the one left standing.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((paddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                hit_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_slave_splitter.sv
// APB4 1-to-N fan-out: zero-latency decode and response mux, default-slave
// error for unmapped addresses, and a per-access timeout for hung completers.
module apb_slave_splitter
    import apb_pkg::*;
#(
    parameter int unsigned                      NUM_SLAVES     = 4,
    parameter int unsigned                      ADDR_WIDTH     = 32,
    parameter int unsigned                      DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE       = {32'h4000_3000, 32'h4000_2000,
                                                                  32'h4000_1000, 32'h4000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK       = {4{32'hFFFF_F000}},
    parameter int unsigned                      TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             m_psel,
    input  logic                             m_penable,
    input  logic                             m_pwrite,
    input  logic [ADDR_WIDTH-1:0]            m_paddr,
    input  logic [DATA_WIDTH-1:0]            m_pwdata,
    output logic [DATA_WIDTH-1:0]            m_prdata,
    output logic                             m_pready,
    output logic                             m_pslverr,
    output logic [NUM_SLAVES-1:0]            s_psel,
    output logic                             s_penable,
    output logic                             s_pwrite,
    output logic [ADDR_WIDTH-1:0]            s_paddr,
    output logic [DATA_WIDTH-1:0]            s_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]            s_pready,
    input  logic [NUM_SLAVES-1:0]            s_pslverr,
    output logic                             timeout_pulse,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic [ERR_CNT_W-1:0]             err_count
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic        TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    splitter_state_t         state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;

    logic [NUM_SLAVES-1:0]   hit;
    logic                    hit_any;
    logic                    sel_pready;
    logic                    sel_pslverr;
    logic [DATA_WIDTH-1:0]   sel_prdata;
    logic                    log_err;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decoder (
        .paddr   (m_paddr),
        .hit     (hit),
        .hit_any (hit_any)
    );

    assign s_penable = m_penable;
    assign s_pwrite  = m_pwrite;
    assign s_paddr   = m_paddr;
    assign s_pwdata  = m_pwdata;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

    // Response mux keyed off the select latched at the SETUP edge.
    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = APB_RESP_OKAY;
        sel_prdata  = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (sel_q[i]) begin
                sel_pready  = s_pready[i];
                sel_pslverr = s_pslverr[i];
                sel_prdata  = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_addr_d    = err_addr_q;
        err_count_d   = err_count_q;
        s_psel        = '0;
        m_pready      = 1'b0;
        m_pslverr     = APB_RESP_OKAY;
        m_prdata      = '0;
        timeout_pulse = 1'b0;
        log_err       = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_psel && hit_any) begin
                    s_psel = hit;
                end
                if (m_psel && !m_penable) begin
                    state_d   = ACCESS;
                    sel_d     = hit_any ? hit : '0;
                    tmo_cnt_d = '0;
                end
            end
            ACCESS: begin
                if (!m_psel) begin
                    state_d = IDLE;
                end else begin
                    s_psel = sel_q;
                    if (sel_q == '0) begin
                        m_pready  = 1'b1;
                        m_pslverr = APB_RESP_ERR;
                        log_err   = 1'b1;
                        state_d   = IDLE;
                    end else if (sel_pready) begin
                        // A ready slave beats a timeout landing on the same cycle.
                        m_pready  = 1'b1;
                        m_pslverr = sel_pslverr;
                        m_prdata  = sel_prdata;
                        state_d   = IDLE;
                    end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                        m_pready      = 1'b1;
                        m_pslverr     = APB_RESP_ERR;
                        timeout_pulse = 1'b1;
                        log_err       = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        m_pslverr = sel_pslverr;
                        m_prdata  = sel_prdata;
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (log_err) begin
            err_addr_d = m_paddr;
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end

        // Keep every completer deselected and the upstream quiet while reset is held.
        if (!resetn) begin
            s_psel        = '0;
            m_pready      = 1'b0;
            m_pslverr     = APB_RESP_OKAY;
            m_prdata      = '0;
            timeout_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            tmo_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_splitter.sv
// Bench for apb_slave_splitter: directed scenarios plus randomized transfers
// checked cycle by cycle against an address-window/wait-count reference model.
module tb_apb_slave_splitter;

    localparam int unsigned NS  = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              m_psel, m_penable, m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic [DW-1:0]     m_prdata;
    logic              m_pready, m_pslverr;
    logic [NS-1:0]     s_psel;
    logic              s_penable, s_pwrite;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic [NS*DW-1:0]  s_prdata;
    logic [NS-1:0]     s_pready, s_pslverr;
    logic              timeout_pulse;
    logic [AW-1:0]     err_addr;
    logic [7:0]        err_count;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] mdl_err_addr = '0;
    int            mdl_err_cnt  = 0;

    always #5 clk = ~clk;

    apb_slave_splitter #(
        .NUM_SLAVES     (NS),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m_psel        (m_psel),
        .m_penable     (m_penable),
        .m_pwrite      (m_pwrite),
        .m_paddr       (m_paddr),
        .m_pwdata      (m_pwdata),
        .m_prdata      (m_prdata),
        .m_pready      (m_pready),
        .m_pslverr     (m_pslverr),
        .s_psel        (s_psel),
        .s_penable     (s_penable),
        .s_pwrite      (s_pwrite),
        .s_paddr       (s_paddr),
        .s_pwdata      (s_pwdata),
        .s_prdata      (s_prdata),
        .s_pready      (s_pready),
        .s_pslverr     (s_pslverr),
        .timeout_pulse (timeout_pulse),
        .err_addr      (err_addr),
        .err_count     (err_count)
    );

    // Memory map: four 4 KiB pages starting at 0x4000_0000, page n -> slave n.
    function automatic int target_of(input logic [AW-1:0] a);
        logic [AW-1:0] page;
        page = a >> 12;
        if (page >= 32'h40000 && page <= 32'h40003) return int'(page - 32'h40000);
        return -1;
    endfunction

    function automatic void log_model_err(input logic [AW-1:0] a);
        mdl_err_addr = a;
        if (mdl_err_cnt < 255) mdl_err_cnt++;
    endfunction

    // Target slave gets the scenario's response; the others get random noise.
    task automatic drive_slaves(input int tgt, input logic rdy, input logic err, input logic [DW-1:0] rd);
        for (int i = 0; i < int'(NS); i++) begin
            if (i == tgt) begin
                s_pready[i]              = rdy;
                s_pslverr[i]             = err;
                s_prdata[i*DW +: DW]     = rd;
            end else begin
                s_pready[i]              = 1'($urandom);
                s_pslverr[i]             = 1'($urandom);
                s_prdata[i*DW +: DW]     = $urandom;
            end
        end
    endtask

    // One full transfer (SETUP + ACCESS); returns the ACCESS cycle count. PSEL is left high.
    task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                            input int waits, input logic serr, input logic [DW-1:0] rd,
                            output int ncyc);
        int            tgt;
        logic [NS-1:0] exp_sel;
        logic          e_rdy, e_err, e_tp;
        logic [DW-1:0] e_data;
        bit            done;
        int            k;
        tgt     = target_of(addr);
        exp_sel = (tgt >= 0) ? (NS'(1) << tgt) : '0;
        done    = 0;
        k       = 0;
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr; m_pwdata = wd;
        drive_slaves(tgt, 1'($urandom), serr, rd);
        @(negedge clk);
        checks++;
        if (s_psel !== exp_sel || m_pready !== 1'b0 || m_prdata !== '0 || timeout_pulse !== 1'b0)
            begin errors++; $display("FAIL setup addr=%h: psel=%b rdy=%b data=%h tp=%b, need psel=%b rdy=0 data=0 tp=0",
                addr, s_psel, m_pready, m_prdata, timeout_pulse, exp_sel); end
        checks++;
        if (s_pwdata !== wd || s_pwrite !== wr || s_paddr !== addr || err_count !== 8'(mdl_err_cnt)
            || err_addr !== mdl_err_addr)
            begin errors++; $display("FAIL passthru/errlog addr=%h: pwdata=%h pwrite=%b paddr=%h cnt=%0d eaddr=%h, need %h %b %h %0d %h",
                addr, s_pwdata, s_pwrite, s_paddr, err_count, err_addr, wd, wr, addr, mdl_err_cnt, mdl_err_addr); end
        while (!done) begin
            k++;
            @(posedge clk); #1;
            m_penable = 1'b1;
            drive_slaves(tgt, (k == waits + 1), serr, rd);
            if (tgt < 0) begin
                e_rdy = 1; e_err = 1; e_data = '0; e_tp = 0; done = 1; log_model_err(addr);
            end else if (k == waits + 1) begin
                e_rdy = 1; e_err = serr; e_data = rd; e_tp = 0; done = 1;
            end else if (k == int'(TMO)) begin
                e_rdy = 1; e_err = 1; e_data = '0; e_tp = 1; done = 1; log_model_err(addr);
            end else begin
                e_rdy = 0; e_err = serr; e_data = rd; e_tp = 0;
            end
            @(negedge clk);
            checks++;
            if (s_psel !== exp_sel || s_penable !== 1'b1 || m_pready !== e_rdy || m_pslverr !== e_err
                || m_prdata !== e_data || timeout_pulse !== e_tp)
                begin errors++; $display("FAIL access addr=%h cyc=%0d: psel=%b en=%b rdy=%b err=%b data=%h tp=%b, need psel=%b en=1 rdy=%b err=%b data=%h tp=%b",
                    addr, k, s_psel, s_penable, m_pready, m_pslverr, m_prdata, timeout_pulse,
                    exp_sel, e_rdy, e_err, e_data, e_tp); end
            if (k >= 20 && !done) begin
                errors++; $display("FAIL bound addr=%h: no completion after %0d cycles", addr, k);
                done = 1;
            end
        end
        ncyc = k;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (s_psel !== '0 || m_pready !== 1'b0 || timeout_pulse !== 1'b0 || err_count !== 8'(mdl_err_cnt)
            || err_addr !== mdl_err_addr)
            begin errors++; $display("FAIL idle: psel=%b rdy=%b tp=%b cnt=%0d eaddr=%h, need 0 0 0 %0d %h",
                s_psel, m_pready, timeout_pulse, err_count, err_addr, mdl_err_cnt, mdl_err_addr); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 32'h4000_1004; m_pwdata = '0;
        s_pready = '1; s_pslverr = '1; s_prdata = '1;
        repeat (2) @(negedge clk);
        checks++;
        if (s_psel !== '0 || m_pready !== 1'b0 || m_pslverr !== 1'b0 || m_prdata !== '0
            || err_count !== 8'd0 || err_addr !== '0 || timeout_pulse !== 1'b0)
            begin errors++; $display("FAIL reset: psel=%b rdy=%b err=%b data=%h cnt=%0d eaddr=%h tp=%b, need all zero",
                s_psel, m_pready, m_pslverr, m_prdata, err_count, err_addr, timeout_pulse); end
        @(posedge clk); #1;
        m_psel = 1'b0; resetn = 1'b1;
        idle_cycle();
    endtask

    task automatic test_write_wait();
        int n;
        run_xfer(32'h4000_1004, 1'b1, 32'hA5A5_A5A5, 2, 1'b0, $urandom, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL write_wait access cycles: got %0d, need 3", n); end
        idle_cycle();
    endtask

    task automatic test_read_zero_wait();
        int n;
        run_xfer(32'h4000_2010, 1'b0, $urandom, 0, 1'b0, 32'hDEAD_BEEF, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL read_zero_wait access cycles: got %0d, need 1", n); end
        idle_cycle();
    endtask

    task automatic test_unmapped();
        int n;
        run_xfer(32'h5000_0000, 1'b0, $urandom, 0, 1'b0, $urandom, n);
        idle_cycle();
        checks++;
        if (err_addr !== 32'h5000_0000 || err_count !== 8'd1)
            begin errors++; $display("FAIL unmapped errlog: eaddr=%h cnt=%0d, need 50000000 1", err_addr, err_count); end
    endtask

    task automatic test_timeout();
        int n;
        run_xfer(32'h4000_3000, 1'b0, $urandom, 1000, 1'b0, $urandom, n);
        checks++;
        if (n !== int'(TMO)) begin errors++; $display("FAIL timeout access cycles: got %0d, need %0d", n, TMO); end
        idle_cycle();
        // Ready on the very cycle the timeout would fire completes normally.
        run_xfer(32'h4000_3040, 1'b0, $urandom, int'(TMO) - 1, 1'b0, 32'h1234_5678, n);
        checks++;
        if (n !== int'(TMO)) begin errors++; $display("FAIL ready_at_timeout cycles: got %0d, need %0d", n, TMO); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        run_xfer(32'h4000_0008, 1'b1, 32'h0BAD_F00D, 1, 1'b0, $urandom, n);
        run_xfer(32'h4000_300C, 1'b0, $urandom, 0, 1'b1, 32'hCAFE_0003, n);
        run_xfer(32'h7000_0000, 1'b1, $urandom, 0, 1'b0, $urandom, n);
        run_xfer(32'h4000_1000, 1'b0, $urandom, 3, 1'b0, 32'h0000_0001, n);
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 32'h4000_2008;
        drive_slaves(2, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        m_penable = 1'b1;
        drive_slaves(2, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        s_pready = '1;
        resetn   = 1'b0;
        #1;
        checks++;
        if (s_psel !== '0 || m_pready !== 1'b0)
            begin errors++; $display("FAIL reset_mid async: psel=%b rdy=%b, need 0 0", s_psel, m_pready); end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge clk); #1;
        resetn       = 1'b1;
        mdl_err_cnt  = 0;
        mdl_err_addr = '0;
        idle_cycle();
        run_xfer(32'h4000_2008, 1'b0, $urandom, 1, 1'b0, 32'h5555_AAAA, n);
        idle_cycle();
    endtask

    task automatic test_random();
        int            n;
        logic [AW-1:0] a;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h6000_0000 ^ ($urandom & 32'h0FFF_FFFF);
                1:       a = 32'h4000_4000 + ($urandom & 32'h0000_FFFF);
                default: a = 32'h4000_0000 + ($urandom & 32'h0000_3FFF);
            endcase
            run_xfer(a, 1'($urandom), $urandom, $urandom_range(0, 9), 1'($urandom), $urandom, n);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        s_pready = '0; s_pslverr = '0; s_prdata = '0;
        test_reset();
        test_write_wait();
        test_read_zero_wait();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
